// File: rtl/gcd_sched_pkg.sv
// Shared types and helpers for the round-robin gcd scheduler.
package gcd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2w(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import gcd_sched_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [IDW-1:0] w_c;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    w_c        = '0;
    for (int k = 0; k < N; k++) begin
      w_c = IDW'((int'(ptr) + k) % N);
      if (!gnt_any && req[w_c]) begin
        gnt_any       = 1'b1;
        gnt_onehot[w_c] = 1'b1;
        gnt_idx       = w_c;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Shares one gcd core among N requesters: arbitrate, issue, watch, respond.
module gcd_sched
  import gcd_sched_pkg::*;
#(
  parameter  int W       = 10,
  parameter  int N       = 4,
  parameter  int TIMEOUT = 1023,
  localparam int IDW     = clog2w(N),
  localparam int CW      = clog2w(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_timeout,
  output logic           busy,
  output logic           core_start,
  output logic [W-1:0]   core_a,
  output logic [W-1:0]   core_b,
  input  logic [W-1:0]   core_result,
  input  logic           core_valid
);

  state_t         r_state;
  logic [IDW-1:0] r_ptr, r_id, r_rsp_id;
  logic [W-1:0]   r_a, r_b, r_res;
  logic [CW-1:0]  r_cnt;
  logic           r_rsp_valid, r_rsp_timeout, r_core_start;

  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_gnt_any;
  logic [W-1:0]   w_a, w_b;

  rr_arbiter #(.N(N)) u_arb (
    .req        (req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt),
    .gnt_idx    (w_gnt_idx),
    .gnt_any    (w_gnt_any)
  );

  assign w_a = req_a[w_gnt_idx*W +: W];
  assign w_b = req_b[w_gnt_idx*W +: W];

  assign req_ready   = (r_state == IDLE && !rst) ? w_gnt : '0;
  assign busy        = (r_state != IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_res;
  assign rsp_timeout = r_rsp_timeout;
  assign core_start  = r_core_start;
  assign core_a      = r_a;
  assign core_b      = r_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_id          <= '0;
      r_rsp_id      <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_res         <= '0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_core_start  <= 1'b0;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        IDLE: if (w_gnt_any) begin
          r_a   <= w_a;
          r_b   <= w_b;
          r_id  <= w_gnt_idx;
          r_ptr <= (w_gnt_idx == IDW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
          // gcd(x,0)=x and gcd(0,0)=0 both reduce to a|b; skip the core.
          if (w_a == '0 || w_b == '0) begin
            r_res         <= w_a | w_b;
            r_rsp_id      <= w_gnt_idx;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_core_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE:  r_state <= SETTLE;
        // core_valid may still be high from the previous op here.
        SETTLE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (core_valid) begin
            r_res         <= core_result;
            r_rsp_id      <= r_id;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else if (r_cnt + 1'b1 == CW'(TIMEOUT)) begin
            r_res         <= '0;
            r_rsp_id      <= r_id;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_rsp_timeout <= 1'b0;
          r_cnt         <= '0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural gcd core stub.
module tb_gcd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [39:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_result;
  logic        rsp_timeout;
  logic        busy;
  logic        core_start;
  logic [9:0]  core_a, core_b;
  logic [9:0]  core_result;
  logic        core_valid;

  gcd_sched #(.W(10), .N(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_result(core_result), .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  // Core stub: result_valid rises dly cycles after start; stall freezes it.
  int   dly = 1;
  bit   stall = 0;
  int   ccnt;
  function automatic logic [9:0] gcd(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      core_valid <= 1'b0; ccnt <= 0; core_result <= '0;
    end else if (core_start) begin
      core_valid <= 1'b0; ccnt <= dly; core_result <= gcd(core_a, core_b);
    end else if (ccnt != 0 && !stall) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) core_valid <= 1'b1;
    end
  end

  int total = 0, bad = 0, cyc = 0, starts = 0;
  int g_id[$], g_cyc[$], r_id[$], r_res[$], r_to[$], r_cyc[$];

  task automatic clear_rec();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_res.delete(); r_to.delete(); r_cyc.delete();
    starts = 0;
  endtask

  task automatic put(input int i, input logic [9:0] a, input logic [9:0] b);
    req_a[i*10 +: 10] = a;
    req_b[i*10 +: 10] = b;
    req_valid[i] = 1'b1;
  endtask

  // Sample at negedge, drop granted requests after the accepting edge.
  task automatic run(input int n_rsp, input int budget, input logic [3:0] hold);
    logic [3:0] pend;
    int b = 0;
    while (b < budget && (n_rsp == 0 || r_res.size() < n_rsp)) begin
      @(negedge clk);
      pend = '0;
      for (int i = 0; i < 4; i++)
        if (req_ready[i]) begin
          g_id.push_back(i); g_cyc.push_back(cyc);
          if (!hold[i]) pend[i] = 1'b1;
        end
      if (rsp_valid) begin
        r_id.push_back(int'(rsp_id)); r_res.push_back(int'(rsp_result));
        r_to.push_back(int'(rsp_timeout)); r_cyc.push_back(cyc);
      end
      if (core_start) starts++;
      @(posedge clk); #1;
      req_valid = req_valid & ~pend;
      cyc++; b++;
    end
    if (n_rsp > 0) begin
      total++;
      if (r_res.size() < n_rsp) begin
        bad++; $display("FAIL rsp_count got=%0d exp=%0d", r_res.size(), n_rsp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hf; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", req_ready); end
    req_valid = '0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start got=%0b exp=0", core_start); end
    total++; if ({rsp_id, rsp_result, rsp_timeout} !== 13'd0) begin
      bad++; $display("FAIL rst_rsp_regs got=%0h exp=0", {rsp_id, rsp_result, rsp_timeout});
    end
    total++; if (core_a !== 10'd0 || core_b !== 10'd0) begin
      bad++; $display("FAIL rst_core_ops got=%0d,%0d exp=0,0", core_a, core_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_single();
    clear_rec(); dly = 1;
    put(0, 10'd752, 10'd168);
    run(1, 50, 4'b0);
    total++; if (r_id[0] !== 0) begin bad++; $display("FAIL single_id got=%0d exp=0", r_id[0]); end
    total++; if (r_res[0] !== 8) begin bad++; $display("FAIL single_result got=%0d exp=8", r_res[0]); end
    total++; if (r_to[0] !== 0) begin bad++; $display("FAIL single_timeout got=%0d exp=0", r_to[0]); end
    total++; if (starts !== 1) begin bad++; $display("FAIL single_starts got=%0d exp=1", starts); end
    total++; if (r_cyc[0] - g_cyc[0] !== 4) begin
      bad++; $display("FAIL single_latency got=%0d exp=4", r_cyc[0] - g_cyc[0]);
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || rsp_result !== 10'd8 || rsp_id !== 2'd0) begin
      bad++; $display("FAIL single_hold got=%0b/%0d/%0d exp=0/8/0", rsp_valid, rsp_result, rsp_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_four();
    int exp_res[4] = '{8, 3, 25, 1};
    reset_dut(); clear_rec(); dly = 3;
    put(0, 10'd752, 10'd168); put(1, 10'd33, 10'd777);
    put(2, 10'd100, 10'd75);  put(3, 10'd17, 10'd5);
    run(4, 200, 4'b0);
    for (int k = 0; k < 4; k++) begin
      total++; if (r_id[k] !== k) begin bad++; $display("FAIL all_id%0d got=%0d exp=%0d", k, r_id[k], k); end
      total++; if (r_res[k] !== exp_res[k]) begin
        bad++; $display("FAIL all_res%0d got=%0d exp=%0d", k, r_res[k], exp_res[k]);
      end
    end
    total++; if (starts !== 4) begin bad++; $display("FAIL all_starts got=%0d exp=4", starts); end
  endtask

  task automatic test_zero();
    clear_rec();
    put(1, 10'd0, 10'd45);
    run(1, 20, 4'b0);
    total++; if (r_res[0] !== 45 || r_id[0] !== 1) begin
      bad++; $display("FAIL zero_res got=%0d/id%0d exp=45/id1", r_res[0], r_id[0]);
    end
    total++; if (r_cyc[0] - g_cyc[0] !== 1) begin
      bad++; $display("FAIL zero_latency got=%0d exp=1", r_cyc[0] - g_cyc[0]);
    end
    clear_rec();
    put(2, 10'd0, 10'd0);
    run(1, 20, 4'b0);
    total++; if (r_res[0] !== 0 || r_to[0] !== 0 || r_id[0] !== 2) begin
      bad++; $display("FAIL zero00 got=%0d/to%0d/id%0d exp=0/to0/id2", r_res[0], r_to[0], r_id[0]);
    end
    total++; if (starts !== 0) begin bad++; $display("FAIL zero_starts got=%0d exp=0", starts); end
  endtask

  task automatic test_timeout();
    clear_rec(); stall = 1;
    put(3, 10'd33, 10'd777);
    run(1, 100, 4'b0);
    total++; if (r_to[0] !== 1 || r_res[0] !== 0) begin
      bad++; $display("FAIL to_flag got=to%0d/%0d exp=to1/0", r_to[0], r_res[0]);
    end
    @(negedge clk);
    total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b exp=0", rsp_timeout); end
    @(posedge clk); #1;
    clear_rec(); stall = 0; dly = 2;
    put(3, 10'd33, 10'd777);
    run(1, 60, 4'b0);
    total++; if (r_res[0] !== 3 || r_to[0] !== 0) begin
      bad++; $display("FAIL to_after got=%0d/to%0d exp=3/to0", r_res[0], r_to[0]);
    end
  endtask

  task automatic test_fairness();
    int exp_id[4] = '{0, 2, 0, 2};
    int exp_res[4] = '{1, 25, 1, 25};
    clear_rec();
    put(0, 10'd17, 10'd5); put(2, 10'd100, 10'd75);
    run(4, 200, 4'b0101);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      total++; if (r_id[k] !== exp_id[k] || r_res[k] !== exp_res[k]) begin
        bad++; $display("FAIL fair%0d got=id%0d/%0d exp=id%0d/%0d", k, r_id[k], r_res[k], exp_id[k], exp_res[k]);
      end
    end
  endtask

  task automatic test_reset_wait();
    clear_rec(); stall = 1;
    put(1, 10'd752, 10'd168);
    run(0, 8, 4'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rstw_idle got=busy%0b/v%0b exp=busy0/v0", busy, rsp_valid);
    end
    clear_rec(); stall = 0;
    run(0, 25, 4'b0);
    total++; if (r_res.size() !== 0 || starts !== 0) begin
      bad++; $display("FAIL rstw_stale got=%0d rsp/%0d starts exp=0/0", r_res.size(), starts);
    end
    clear_rec(); dly = 2;
    put(1, 10'd100, 10'd75);
    run(1, 60, 4'b0);
    total++; if (r_res[0] !== 25 || r_id[0] !== 1) begin
      bad++; $display("FAIL rstw_after got=%0d/id%0d exp=25/id1", r_res[0], r_id[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_zero();
    test_timeout();
    test_fairness();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
